crc_engine: RTL and testbench



---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_lfsr_step.sv | 21 ++
 rtl/crc_engine.sv | 116 +++++++++++
 tb/tb_crc_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the serial CRC engine.
// Provides the CRC16 (Select/access) and CRC5 (Query) parameter sets.
package crc_pkg;

    localparam logic [15:0] CRC16_POLY       = 16'h1021;
    localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE    = 16'h1D0F;
    localparam logic        CRC16_INVERT_OUT = 1'b1;

    localparam logic [4:0]  CRC5_POLY        = 5'h09;
    localparam logic [4:0]  CRC5_INIT        = 5'h09;
    localparam logic [4:0]  CRC5_RESIDUE     = 5'h00;
    localparam logic        CRC5_INVERT_OUT  = 1'b0;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_SHIFT = 1'b1
    } crc_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit serial CRC update (MSB-first), purely combinational.
// Shared with the TX-side CRC generator.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = CRC16_POLY
) (
    input  logic [WIDTH-1:0] crc_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] crc_next_o
);

    logic fb;

    always_comb begin
        fb         = bit_i ^ crc_i[WIDTH-1];
        crc_next_o = {crc_i[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_engine.sv
// Serial CRC engine: accumulates received bits, checks the residue and
// serialises the (optionally complemented) CRC MSB-first for replies.
module crc_engine
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = CRC16_POLY,
    parameter logic [WIDTH-1:0] INIT       = CRC16_INIT,
    parameter logic [WIDTH-1:0] RESIDUE    = CRC16_RESIDUE,
    parameter logic             INVERT_OUT = CRC16_INVERT_OUT
) (
    input  logic             crcinclk,
    input  logic             reset,
    input  logic             start,
    input  logic             bitin_valid,
    input  logic             crcbitin,
    input  logic             check,
    input  logic             gen,
    output logic [WIDTH-1:0] crc,
    output logic             crc_valid,
    output logic             crc_ok,
    output logic             bitout,
    output logic             bitout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    crc_state_e       state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [WIDTH-1:0] crc_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crc_valid_q, crc_valid_d;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .crc_i      (crc_q),
        .bit_i      (crcbitin),
        .crc_next_o (crc_next)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        crc_ok_d    = crc_ok_q;
        crc_valid_d = 1'b0;
        unique case (state_q)
            ST_ACC: begin
                if (start) begin
                    crc_d    = INIT;
                    crc_ok_d = 1'b0;
                end else if (gen) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_TOP;
                end else begin
                    if (bitin_valid) begin
                        crc_d = crc_next;
                    end
                    // crc_d already holds the post-update value when a bit arrives with check
                    if (check) begin
                        crc_ok_d    = (crc_d == RESIDUE);
                        crc_valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    state_d  = ST_ACC;
                    crc_d    = INIT;
                    crc_ok_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge crcinclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACC;
            crc_q       <= INIT;
            cnt_q       <= '0;
            crc_ok_q    <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            crc_ok_q    <= crc_ok_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    // Serial outputs decode straight from the SHIFT state so the first bit
    // appears the cycle after gen and done coincides with the last bit.
    always_comb begin
        busy         = (state_q == ST_SHIFT);
        bitout_valid = busy;
        bitout       = busy & (crc_q[cnt_q] ^ INVERT_OUT);
        done         = busy && (cnt_q == '0);
    end

    assign crc       = crc_q;
    assign crc_ok    = crc_ok_q;
    assign crc_valid = crc_valid_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed scoreboard bench for crc_engine: CRC16 and CRC5 instances,
// known answers, residue checks, simultaneous events, abort and reset.
module tb_crc_engine;

    logic clk = 1'b0;
    logic reset;

    logic        s16, bv16, b16, ck16, g16;
    logic [15:0] crc16o;
    logic        cv16, ok16, bo16, bov16, busy16, done16;

    logic        s5, bv5, b5, ck5, g5;
    logic [4:0]  crc5o;
    logic        cv5, ok5, bo5, bov5, busy5, done5;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [31:0] m16;
    logic [31:0] m5;
    logic        ok_q[$];
    logic        ok5_q[$];
    logic        bit_q[$];
    string       msg = "123456789";

    always #5 clk = ~clk;

    crc_engine dut16 (
        .crcinclk(clk), .reset(reset), .start(s16), .bitin_valid(bv16),
        .crcbitin(b16), .check(ck16), .gen(g16), .crc(crc16o),
        .crc_valid(cv16), .crc_ok(ok16), .bitout(bo16),
        .bitout_valid(bov16), .busy(busy16), .done(done16)
    );

    crc_engine #(
        .WIDTH(5), .POLY(5'h09), .INIT(5'h09), .RESIDUE(5'h00), .INVERT_OUT(1'b0)
    ) dut5 (
        .crcinclk(clk), .reset(reset), .start(s5), .bitin_valid(bv5),
        .crcbitin(b5), .check(ck5), .gen(g5), .crc(crc5o),
        .crc_valid(cv5), .crc_ok(ok5), .bitout(bo5),
        .bitout_valid(bov5), .busy(busy5), .done(done5)
    );

    function automatic logic [31:0] step(input logic [31:0] c, input logic b,
                                         input int unsigned w, input logic [31:0] poly);
        logic        fb;
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        fb   = b ^ c[w-1];
        c    = (c << 1) & mask;
        if (fb) c = c ^ poly;
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start16;
        s16 = 1'b1; m16 = 32'hFFFF;
        tick;
        s16 = 1'b0;
    endtask

    task automatic feed16(input logic b, input logic ck);
        bv16 = 1'b1; b16 = b; ck16 = ck;
        m16 = step(m16, b, 16, 32'h1021);
        if (ck) ok_q.push_back(m16[15:0] == 16'h1D0F);
        tick;
        bv16 = 1'b0; ck16 = 1'b0;
    endtask

    task automatic feed16_byte(input logic [7:0] by, input logic ck_last);
        for (int k = 7; k >= 0; k--) feed16(by[k], ck_last && (k == 0));
    endtask

    task automatic feed16_word(input logic [15:0] w, input logic ck_last);
        for (int k = 15; k >= 0; k--) feed16(w[k], ck_last && (k == 0));
    endtask

    task automatic check16;
        ck16 = 1'b1;
        ok_q.push_back(m16[15:0] == 16'h1D0F);
        tick;
        ck16 = 1'b0;
    endtask

    task automatic ok_result16(input string tag);
        logic e;
        e = (ok_q.size() != 0) ? ok_q.pop_front() : 1'bx;
        chk({tag, "_valid"}, cv16, 1'b1);
        chk({tag, "_ok"}, ok16, e);
    endtask

    task automatic gen16(input logic with_bit, input logic bitval, input string tag);
        logic [15:0] cur;
        logic        e;
        cur = m16[15:0];
        for (int i = 15; i >= 0; i--) bit_q.push_back(~cur[i]);
        g16 = 1'b1; bv16 = with_bit; b16 = bitval;
        tick;
        g16 = 1'b0; bv16 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            e = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
            chk({tag, "_busy"}, busy16, 1'b1);
            chk({tag, "_bov"}, bov16, 1'b1);
            chk({tag, "_bit"}, bo16, e);
            chk({tag, "_done"}, done16, (c == 16));
            chk({tag, "_crc_hold"}, crc16o, cur);
            tick;
        end
        chk({tag, "_busy_end"}, busy16, 1'b0);
        chk({tag, "_bov_end"}, bov16, 1'b0);
        chk({tag, "_done_end"}, done16, 1'b0);
        chk({tag, "_crc_end"}, crc16o, cur);
        chk({tag, "_sb_empty"}, bit_q.size(), 0);
    endtask

    task automatic feed5(input logic b);
        bv5 = 1'b1; b5 = b;
        m5 = step(m5, b, 5, 32'h09);
        tick;
        bv5 = 1'b0;
    endtask

    initial begin
        logic [15:0] cur;
        logic        e;
        logic [7:0]  by;

        reset = 1'b1;
        {s16, bv16, b16, ck16, g16} = '0;
        {s5, bv5, b5, ck5, g5} = '0;
        m16 = 32'hFFFF; m5 = 32'h09;
        tick; tick;
        chk("rst_crc", crc16o, 16'hFFFF);
        chk("rst_ok", ok16, 1'b0);
        chk("rst_valid", cv16, 1'b0);
        chk("rst_bov", bov16, 1'b0);
        chk("rst_bitout", bo16, 1'b0);
        chk("rst_busy", busy16, 1'b0);
        chk("rst_done", done16, 1'b0);
        chk("rst_crc5", crc5o, 5'h09);
        #2 reset = 1'b0;
        tick;

        start16;
        chk("start_crc", crc16o, 16'hFFFF);
        chk("start_ok", ok16, 1'b0);
        chk("start_bov", bov16, 1'b0);
        chk("start_busy", busy16, 1'b0);

        // Known answer and serialisation
        feed16_byte(msg[0], 1'b0);
        chk("kat_byte0", crc16o, m16);
        for (int i = 1; i < 9; i++) feed16_byte(msg[i], 1'b0);
        chk("kat_crc", crc16o, 16'h29B1);
        gen16(1'b0, 1'b0, "kat_gen");

        // Residue with check on its own cycle
        start16;
        for (int i = 0; i < 9; i++) feed16_byte(msg[i], 1'b0);
        feed16_word(16'hD64E, 1'b0);
        check16;
        ok_result16("res_sep");
        chk("res_crc", crc16o, 16'h1D0F);
        tick;
        chk("res_pulse_end", cv16, 1'b0);
        chk("res_sticky", ok16, 1'b1);

        // Bad frame
        start16;
        for (int i = 0; i < 9; i++) begin
            by = msg[i];
            if (i == 0) by = by ^ 8'h01;
            feed16_byte(by, 1'b0);
        end
        feed16_word(16'hD64E, 1'b0);
        check16;
        ok_result16("bad");
        chk("bad_ok_const", ok16, 1'b0);

        // Check together with last absorbed bit
        start16;
        for (int i = 0; i < 9; i++) feed16_byte(msg[i], 1'b0);
        feed16_word(16'hD64E, 1'b1);
        ok_result16("simul_chk");
        chk("simul_ok_const", ok16, 1'b1);

        // Start together with bitin_valid
        s16 = 1'b1; bv16 = 1'b1; b16 = 1'b1; m16 = 32'hFFFF;
        tick;
        s16 = 1'b0; bv16 = 1'b0;
        chk("start_bit_crc", crc16o, 16'hFFFF);
        chk("start_bit_ok", ok16, 1'b0);

        // Gen together with bitin_valid: bit dropped
        feed16_byte(msg[0], 1'b0);
        gen16(1'b1, 1'b1, "gen_bit");

        // Abort at the 6th SHIFT cycle
        start16;
        feed16_byte(8'h41, 1'b0);
        cur = m16[15:0];
        g16 = 1'b1;
        tick;
        g16 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            e = ~cur[16 - c];
            chk("abort_bov", bov16, 1'b1);
            chk("abort_bit", bo16, e);
            chk("abort_nodone", done16, 1'b0);
            if (c == 6) begin
                s16 = 1'b1;
                m16 = 32'hFFFF;
            end
            tick;
        end
        s16 = 1'b0;
        chk("abort_bov_drop", bov16, 1'b0);
        chk("abort_busy_drop", busy16, 1'b0);
        chk("abort_done", done16, 1'b0);
        chk("abort_crc", crc16o, 16'hFFFF);
        tick;
        chk("abort_done_later", done16, 1'b0);

        // Async reset mid-shift with crc_ok set
        for (int i = 0; i < 9; i++) feed16_byte(msg[i], 1'b0);
        feed16_word(16'hD64E, 1'b1);
        ok_result16("pre_rst");
        g16 = 1'b1;
        tick;
        g16 = 1'b0;
        tick;
        chk("pre_rst_busy", busy16, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_crc", crc16o, 16'hFFFF);
        chk("arst_ok", ok16, 1'b0);
        chk("arst_valid", cv16, 1'b0);
        chk("arst_bov", bov16, 1'b0);
        chk("arst_bitout", bo16, 1'b0);
        chk("arst_busy", busy16, 1'b0);
        chk("arst_done", done16, 1'b0);
        #1 reset = 1'b0;
        m16 = 32'hFFFF;
        tick;
        chk("post_rst_busy", busy16, 1'b0);
        chk("post_rst_crc", crc16o, 16'hFFFF);

        // CRC5 instance
        s5 = 1'b1; m5 = 32'h09;
        tick;
        s5 = 1'b0;
        chk("c5_start", crc5o, 5'h09);
        for (int i = 0; i < 9; i++) begin
            by = msg[i];
            for (int k = 7; k >= 0; k--) feed5(by[k]);
        end
        chk("c5_kat", crc5o, 5'h00);
        chk("c5_model", crc5o, m5[4:0]);
        for (int k = 0; k < 5; k++) feed5(1'b0);
        ck5 = 1'b1;
        ok5_q.push_back(m5[4:0] == 5'h00);
        tick;
        ck5 = 1'b0;
        e = (ok5_q.size() != 0) ? ok5_q.pop_front() : 1'bx;
        chk("c5_valid", cv5, 1'b1);
        chk("c5_ok", ok5, e);

        s5 = 1'b1; m5 = 32'h09;
        tick;
        s5 = 1'b0;
        for (int k = 7; k >= 0; k--) feed5(msg[0][k]);
        for (int i = 4; i >= 0; i--) bit_q.push_back(m5[i]);
        g5 = 1'b1;
        tick;
        g5 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            e = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
            chk("c5_bov", bov5, 1'b1);
            chk("c5_bit", bo5, e);
            chk("c5_done", done5, (c == 5));
            tick;
        end
        chk("c5_busy_end", busy5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
